// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle mult/div engine that owns the HI/LO pair.
// Ports: start/is_mult/is_unsigned/a/b issue, wr_* mthi/mtlo,
//        rd_* mfhi/mflo, rdata/hi/lo data, busy/stall/done/div_by_zero.
module muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            is_mult,
    input  logic            is_unsigned,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            wr_en,
    input  logic            wr_hi,
    input  logic [XLEN-1:0] wr_data,
    input  logic            rd_req,
    input  logic            rd_hi,
    output logic [XLEN-1:0] rdata,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic            div_by_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

    state_t state, state_nxt;

    logic [CNT_W-1:0]  count;
    logic              op_mult;
    logic              neg_q;
    logic              neg_r;
    logic              dz;
    logic [XLEN-1:0]   a_orig;
    logic [XLEN-1:0]   mcand;
    logic [XLEN-1:0]   quo;
    logic [XLEN:0]     rem;
    logic [2*XLEN-1:0] acc;

    logic              accept;
    logic              signed_op;
    logic [XLEN-1:0]   a_abs;
    logic [XLEN-1:0]   b_abs;
    logic [XLEN:0]     add_sum;
    logic [2*XLEN-1:0] acc_nxt;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     rem_diff;
    logic              q_bit;

    assign busy      = (state != IDLE);
    assign stall     = busy & (start | wr_en | rd_req);
    assign rdata     = rd_hi ? hi : lo;
    assign accept    = (state == IDLE) & start;
    assign signed_op = ~is_unsigned;
    assign a_abs     = (signed_op & a[XLEN-1]) ? -a : a;
    assign b_abs     = (signed_op & b[XLEN-1]) ? -b : b;

    // Shift-add: upper half gains the multiplicand when the
    // current multiplier bit (acc LSB) is set, then all shifts right.
    assign add_sum = {1'b0, acc[2*XLEN-1:XLEN]}
                   + {1'b0, (acc[0] ? mcand : '0)};
    assign acc_nxt = {add_sum, acc[XLEN-1:1]};

    // Restoring divide: remainder stays below the divisor, so the
    // XLEN+1 bit difference has a trustworthy sign bit.
    assign rem_sh   = {rem[XLEN-1:0], quo[XLEN-1]};
    assign rem_diff = rem_sh - {1'b0, mcand};
    assign q_bit    = ~rem_diff[XLEN];

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = CALC;
            CALC: if (count == LAST) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count   <= '0;
            op_mult <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dz      <= 1'b0;
            a_orig  <= '0;
            mcand   <= '0;
            quo     <= '0;
            rem     <= '0;
            acc     <= '0;
        end else if (accept) begin
            count   <= '0;
            op_mult <= is_mult;
            neg_q   <= signed_op & (a[XLEN-1] ^ b[XLEN-1]);
            neg_r   <= signed_op & a[XLEN-1];
            dz      <= ~is_mult & (b == '0);
            a_orig  <= a;
            mcand   <= b_abs;
            quo     <= a_abs;
            rem     <= '0;
            acc     <= {{XLEN{1'b0}}, a_abs};
        end else if (state == CALC) begin
            count <= count + 1'b1;
            if (op_mult) begin
                acc <= acc_nxt;
            end else begin
                rem <= q_bit ? rem_diff : rem_sh;
                quo <= {quo[XLEN-2:0], q_bit};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= (state == FIX);
            div_by_zero <= (state == FIX) & dz;
            if (state == FIX) begin
                if (op_mult) begin
                    {hi, lo} <= neg_q ? -acc : acc;
                end else if (dz) begin
                    hi <= a_orig;
                    lo <= '1;
                end else begin
                    lo <= neg_q ? -quo : quo;
                    hi <= neg_r ? -rem[XLEN-1:0] : rem[XLEN-1:0];
                end
            end else if (state == IDLE && wr_en && !start) begin
                if (wr_hi) hi <= wr_data;
                else       lo <= wr_data;
            end
        end
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle controller for the multiply/divide resource and the Lo/Hi register pair. It replaces the single-cycle combinational mult/div path with a 32-iteration shift-add / restoring-divide sequence and owns HI/LO. It arbitrates pipeline accesses to HI/LO (mult/div/mthi/mtlo/mfhi/mflo) and raises a stall to the pipeline while an operation is in flight. It sits beside the ALU in EX and is driven by decoded control signals.

Parameters:
XLEN, 32, operand width; HI/LO are XLEN each.
CNT_W, 5, iteration counter width; must satisfy 2**CNT_W == XLEN.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
start  in  1  issue mult/div this cycle
is_mult  in  1  1 = multiply, 0 = divide (sampled with start)
is_unsigned  in  1  1 = unsigned operation (sampled with start)
a  in  XLEN  operand rs (sampled with start)
b  in  XLEN  operand rt (sampled with start)
wr_en  in  1  mthi/mtlo request
wr_hi  in  1  1 = write HI, 0 = write LO
wr_data  in  XLEN  data for mthi/mtlo
rd_req  in  1  mfhi/mflo request
rd_hi  in  1  1 = read HI, 0 = read LO
rdata  out  XLEN  rd_hi ? HI : LO, combinational
busy  out  1  operation in flight
stall  out  1  hold the requesting pipeline stage
done  out  1  one-cycle pulse when HI/LO are updated
div_by_zero  out  1  one-cycle pulse with done when divisor was 0
hi  out  XLEN  HI register
lo  out  XLEN  LO register

Behaviour:
- Reset (rst=0, async): state=IDLE, count=0, HI=LO=0, internal regs=0; busy=stall=done=div_by_zero=0. Reset during CALC or FIX aborts the operation with no HI/LO update.
- States: IDLE, CALC, FIX. busy = (state != IDLE).
- IDLE, start=1 at edge E0: latch is_mult and is_unsigned. Signed ops latch |a| and |b|, neg_q = a[XLEN-1]^b[XLEN-1], neg_r = a[XLEN-1]; unsigned ops latch the raw operands with neg_q = neg_r = 0. Latch dz = (~is_mult & b==0). count=0, go to CALC.
- CALC: one iteration per cycle. Mult: shift-add into a 2*XLEN accumulator. Div: restoring, one quotient bit per cycle, remainder XLEN+1 bits. At count==XLEN-1, go to FIX, so CALC lasts exactly XLEN cycles.
- FIX, one cycle, then go to IDLE:
  - Mult: {HI,LO} = neg_q ? -prod : prod (2*XLEN two's complement).
  - Div: LO = neg_q ? -q : q; HI = neg_r ? -r : r.
  - dz=1 overrides both: HI=a (original), LO={XLEN{1}}, no sign fixup.
  - Signed 0x80000000 / -1 gives LO=0x80000000, HI=0 (natural wrap; no trap).
- done and div_by_zero are registered. Both are high in the cycle after the FIX edge (E0+XLEN+1), i.e. 33 edges after E0 for XLEN=32.
- stall = busy & (start | wr_en | rd_req), combinational. The pipeline holds the request asserted; it is accepted on the first IDLE cycle.
- IDLE, wr_en=1 and start=0: write wr_data to HI or LO at the edge. If start and wr_en are both 1, start wins and the write is dropped (no stall).
- rd_req in IDLE: no stall; rdata reflects the current HI/LO. In the cycle done=1, rdata already shows the new values.
- start, wr_en and rd_req seen while busy never disturb the operation in flight.
- HI/LO change only on a FIX edge, an accepted wr_en, or reset.

Test Plan:
- Signed mult a=0xFFFFFFFD (-3), b=7 -> after 33 edges HI=0xFFFFFFFF, LO=0xFFFFFFEB; done high for 1 cycle; busy high for exactly 33 cycles.
- multu a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Signed mult of the same operands -> HI=0, LO=1.
- Signed div a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu a=7, b=2 -> LO=3, HI=1. Signed div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero, a=5, b=0 (signed and unsigned) -> HI=5, LO=0xFFFFFFFF; div_by_zero pulses with done.
- mflo (rd_req=1, rd_hi=0) held from the cycle after start -> stall=1 every busy cycle, 0 in the done cycle with rdata = new LO. mthi held while busy -> applied on the first IDLE edge.
- Pre-load HI=0x1234 via mthi; start a mult; drive rst=0 at CALC count=10 -> busy=done=0 and HI=LO=0 immediately (async). Next start after rst release behaves normally.
